// File: rtl/gpio_apb_pkg.sv
// Shared definitions for the APB GPIO controller: register offsets, pin limit,
// register-select enum and the address decoder.
package gpio_apb_pkg;

    localparam int MAX_PINS = 32;
    localparam int DBCNT_W  = 16;

    localparam logic [5:0] OFF_DIN      = 6'h00;
    localparam logic [5:0] OFF_DOUT     = 6'h04;
    localparam logic [5:0] OFF_DIR      = 6'h08;
    localparam logic [5:0] OFF_IMASK    = 6'h0C;
    localparam logic [5:0] OFF_IPOL     = 6'h10;
    localparam logic [5:0] OFF_IEDGE    = 6'h14;
    localparam logic [5:0] OFF_IPEND    = 6'h18;
    localparam logic [5:0] OFF_DBCNT    = 6'h1C;
    localparam logic [5:0] OFF_DOUT_SET = 6'h20;
    localparam logic [5:0] OFF_DOUT_CLR = 6'h24;

    typedef enum logic [3:0] {
        SEL_DIN, SEL_DOUT, SEL_DIR, SEL_IMASK, SEL_IPOL, SEL_IEDGE,
        SEL_IPEND, SEL_DBCNT, SEL_SET, SEL_CLR, SEL_NONE
    } reg_sel_e;

    // DBCNT only decodes when the debounce filter is built in.
    function automatic reg_sel_e decode_sel(input logic [5:0] off, input bit db_en);
        case (off & 6'h3C)
            OFF_DIN:      return SEL_DIN;
            OFF_DOUT:     return SEL_DOUT;
            OFF_DIR:      return SEL_DIR;
            OFF_IMASK:    return SEL_IMASK;
            OFF_IPOL:     return SEL_IPOL;
            OFF_IEDGE:    return SEL_IEDGE;
            OFF_IPEND:    return SEL_IPEND;
            OFF_DBCNT:    return db_en ? SEL_DBCNT : SEL_NONE;
            OFF_DOUT_SET: return SEL_SET;
            OFF_DOUT_CLR: return SEL_CLR;
            default:      return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_apb_irq_debounce.sv
// Input debounce filter: shared prescaler tick plus a per-pin 2-bit stability
// counter. Only instantiated when GPIO_DEBOUNCE_EN is defined.
module gpio_debounce
    import gpio_apb_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [DBCNT_W-1:0] dbcnt,
    input  logic [NBITS-1:0]   din,
    output logic [NBITS-1:0]   dout
);

    logic [DBCNT_W-1:0]      presc_q, presc_d;
    logic [NBITS-1:0]        filt_q, filt_d;
    logic [NBITS-1:0][1:0]   stab_q, stab_d;
    logic                    tick;
    logic                    bypass;

    assign bypass = (dbcnt == '0);
    assign tick   = (presc_q == '0);

    // A pin's filtered value moves only after three ticks in a row that all
    // disagree with it; one agreeing tick restarts the count.
    always_comb begin
        presc_d = tick ? dbcnt : presc_q - 1'b1;
        filt_d  = filt_q;
        stab_d  = stab_q;
        for (int i = 0; i < NBITS; i++) begin
            if (bypass) begin
                filt_d[i] = din[i];
                stab_d[i] = 2'd0;
            end else if (tick) begin
                if (din[i] != filt_q[i]) begin
                    if (stab_q[i] == 2'd2) begin
                        filt_d[i] = din[i];
                        stab_d[i] = 2'd0;
                    end else begin
                        stab_d[i] = stab_q[i] + 2'd1;
                    end
                end else begin
                    stab_d[i] = 2'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_q <= '0;
            filt_q  <= '0;
            stab_q  <= '0;
        end else begin
            presc_q <= presc_d;
            filt_q  <= filt_d;
            stab_q  <= stab_d;
        end
    end

    assign dout = bypass ? din : filt_q;

endmodule

// File: rtl/gpio_apb_irq.sv
// APB GPIO controller with per-pin direction, atomic set/clear and edge/level
// interrupts. Define GPIO_DEBOUNCE_EN to add the DBCNT register and input filter.
module gpio_apb_irq
    import gpio_apb_pkg::*;
#(
    parameter int               NBITS    = 8,
    parameter int               ADDR_W   = 12,
    parameter bit               OEPOL    = 1'b0,
    parameter logic [NBITS-1:0] DOUT_RST = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              apb_psel,
    input  logic              apb_penable,
    input  logic [ADDR_W-1:0] apb_paddr,
    input  logic              apb_pwrite,
    input  logic [31:0]       apb_pwdata,
    output logic [31:0]       apb_prdata,
    output logic              apb_pready,
    output logic              apb_pslverr,
    input  logic [NBITS-1:0]  gpio_din,
    output logic [NBITS-1:0]  gpio_dout,
    output logic [NBITS-1:0]  gpio_oen,
    output logic              gpio_irq
);

`ifdef GPIO_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic [NBITS-1:0] dout_q, dout_d, dir_q, dir_d, imask_q, imask_d;
    logic [NBITS-1:0] ipol_q, ipol_d, iedge_q, iedge_d, ipend_q, ipend_d;
    logic [NBITS-1:0] sync1_q, sync2_q, s_prev_q, s;
    logic [NBITS-1:0] wdata, w1c, edge_ev, level_ev;
    logic             irq_q, irq_d;
    logic [31:0]      addr_ext;
    logic             access, wr_en, rd_en, unused_ok;
    reg_sel_e         sel;
    logic [DBCNT_W-1:0] dbcnt_rd;

    // Anything above the 64-byte register window is unmapped.
    assign addr_ext  = 32'(apb_paddr);
    assign sel       = (addr_ext[31:6] == '0) ? decode_sel(addr_ext[5:0], DB_EN) : SEL_NONE;
    assign access    = apb_psel & apb_penable;
    assign wr_en     = access & apb_pwrite & (sel != SEL_NONE);
    assign rd_en     = access & ~apb_pwrite;
    assign wdata     = apb_pwdata[NBITS-1:0];
    assign unused_ok = ^{apb_pwdata, addr_ext[1:0]};

`ifdef GPIO_DEBOUNCE_EN
    logic [DBCNT_W-1:0] dbcnt_q, dbcnt_d;

    always_comb begin
        dbcnt_d = dbcnt_q;
        if (wr_en && sel == SEL_DBCNT) dbcnt_d = apb_pwdata[DBCNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) dbcnt_q <= '1;
        else       dbcnt_q <= dbcnt_d;
    end

    gpio_debounce #(.NBITS(NBITS)) u_debounce (
        .clk   (clk),
        .rstn  (rstn),
        .dbcnt (dbcnt_q),
        .din   (sync2_q),
        .dout  (s)
    );
    assign dbcnt_rd = dbcnt_q;
`else
    assign s        = sync2_q;
    assign dbcnt_rd = '0;
`endif

    // A set event in the same cycle as a write-1-to-clear keeps the bit pending.
    always_comb begin
        dout_d  = dout_q;
        dir_d   = dir_q;
        imask_d = imask_q;
        ipol_d  = ipol_q;
        iedge_d = iedge_q;
        w1c     = '0;
        if (wr_en) begin
            case (sel)
                SEL_DOUT:  dout_d  = wdata;
                SEL_DIR:   dir_d   = wdata;
                SEL_IMASK: imask_d = wdata;
                SEL_IPOL:  ipol_d  = wdata;
                SEL_IEDGE: iedge_d = wdata;
                SEL_IPEND: w1c     = wdata;
                SEL_SET:   dout_d  = dout_q | wdata;
                SEL_CLR:   dout_d  = dout_q & ~wdata;
                default:   ;
            endcase
        end
        edge_ev  = (ipol_q & s & ~s_prev_q) | (~ipol_q & ~s & s_prev_q);
        level_ev = ~(s ^ ipol_q);
        ipend_d  = (ipend_q & ~w1c) | (iedge_q & edge_ev) | (~iedge_q & level_ev);
        irq_d    = |(ipend_q & imask_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q   <= DOUT_RST;
            dir_q    <= '0;
            imask_q  <= '0;
            ipol_q   <= '0;
            iedge_q  <= '0;
            ipend_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            s_prev_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            dout_q   <= dout_d;
            dir_q    <= dir_d;
            imask_q  <= imask_d;
            ipol_q   <= ipol_d;
            iedge_q  <= iedge_d;
            ipend_q  <= ipend_d;
            sync1_q  <= gpio_din;
            sync2_q  <= sync1_q;
            s_prev_q <= s;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        apb_prdata = '0;
        if (rd_en) begin
            case (sel)
                SEL_DIN:   apb_prdata = 32'(s);
                SEL_DOUT:  apb_prdata = 32'(dout_q);
                SEL_DIR:   apb_prdata = 32'(dir_q);
                SEL_IMASK: apb_prdata = 32'(imask_q);
                SEL_IPOL:  apb_prdata = 32'(ipol_q);
                SEL_IEDGE: apb_prdata = 32'(iedge_q);
                SEL_IPEND: apb_prdata = 32'(ipend_q);
                SEL_DBCNT: apb_prdata = 32'(dbcnt_rd);
                default:   apb_prdata = '0;
            endcase
        end
    end

    assign apb_pready  = 1'b1;
    assign apb_pslverr = access & (sel == SEL_NONE);
    assign gpio_dout   = dout_q;
    assign gpio_oen    = OEPOL ? dir_q : ~dir_q;
    assign gpio_irq    = irq_q;

endmodule

// File: tb/tb_gpio_apb_irq.sv
// Scoreboard bench for gpio_apb_irq: expected read data is queued when a read is
// launched and compared in the access phase. Covers GPIO_DEBOUNCE_EN if defined.
module tb_gpio_apb_irq;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        apb_psel, apb_penable, apb_pwrite;
    logic [11:0] apb_paddr;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready, apb_pslverr;
    logic [7:0]  gpio_din, gpio_dout, gpio_oen;
    logic        gpio_irq;

    rd_exp_t     exp_q[$];
    string       tag_q[$];
    int          compared   = 0;
    int          mismatched = 0;

    gpio_apb_irq #(
        .NBITS(8), .ADDR_W(12), .OEPOL(1'b0), .DOUT_RST(8'hA5)
    ) dut (
        .clk(clk), .rstn(rstn),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_paddr(apb_paddr),
        .apb_pwrite(apb_pwrite), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
        .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
        .gpio_din(gpio_din), .gpio_dout(gpio_dout), .gpio_oen(gpio_oen),
        .gpio_irq(gpio_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] data, input logic err);
        rd_exp_t e;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic popAndCheck();
        rd_exp_t e;
        string   t;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checkOutput({t, "_data"}, apb_prdata, e.data);
            checkOutput({t, "_err"}, 32'(apb_pslverr), 32'(e.err));
        end
    endtask

    task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = addr; apb_pwdata = data;
        @(posedge clk); #1;
        apb_penable = 1'b1;
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
    endtask

    task automatic apbRead(input string tag, input logic [11:0] addr,
                           input logic [31:0] exp, input logic err);
        pushExpect(tag, exp, err);
        @(posedge clk); #1;
        apb_psel = 1'b1; apb_pwrite = 1'b0; apb_paddr = addr;
        @(posedge clk); #1;
        apb_penable = 1'b1;
        #1 popAndCheck();
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
        apb_paddr = '0; apb_pwdata = '0; gpio_din = '0;
        repeat (3) @(posedge clk);
        #1;
        apb_psel = 1'b1; apb_paddr = 12'h018;
        pushExpect("ipend_rst", 32'h0, 1'b0);
        @(negedge clk);
        rstn = 1'b1; apb_penable = 1'b1;
        #1 popAndCheck();
        checkOutput("dout_rst", 32'(gpio_dout), 32'h0000_00A5);
        checkOutput("oen_rst", 32'(gpio_oen), 32'h0000_00FF);
        checkOutput("irq_rst", 32'(gpio_irq), 32'h0);
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
        apbRead("dbcnt_rst", 12'h01C, 32'h0000_FFFF, 1'b0);
        applyStimulus(12'h01C, 32'h0);
`endif
        // All pins into edge mode, then clear the level-mode pendings from reset.
        applyStimulus(12'h014, 32'hFF);
        applyStimulus(12'h018, 32'hFF);
        apbRead("ipend_clr", 12'h018, 32'h0, 1'b0);

        applyStimulus(12'h008, 32'h0F);
        applyStimulus(12'h004, 32'h3C);
        applyStimulus(12'h020, 32'h80);
        applyStimulus(12'h024, 32'h04);
        checkOutput("dout_setclr", 32'(gpio_dout), 32'hB8);
        checkOutput("oen_dir", 32'(gpio_oen), 32'hF0);
        apbRead("dout_rd", 12'h004, 32'hB8, 1'b0);
        apbRead("dir_rd", 12'h008, 32'h0F, 1'b0);
        apbRead("set_wo", 12'h020, 32'h0, 1'b0);

        applyStimulus(12'h010, 32'h01);
        applyStimulus(12'h00C, 32'h01);
        gpio_din[0] = 1'b1;
        waitCycles(3);
        checkOutput("irq_edge3", 32'(gpio_irq), 32'h0);
        waitCycles(1);
        checkOutput("irq_edge4", 32'(gpio_irq), 32'h1);
        apbRead("ipend_edge0", 12'h018, 32'h01, 1'b0);
        applyStimulus(12'h018, 32'h01);
        checkOutput("irq_at_clear", 32'(gpio_irq), 32'h1);
        waitCycles(1);
        checkOutput("irq_cleared", 32'(gpio_irq), 32'h0);

        applyStimulus(12'h010, 32'h03);
        applyStimulus(12'h014, 32'hFD);
        gpio_din[1] = 1'b1;
        waitCycles(4);
        applyStimulus(12'h018, 32'h02);
        apbRead("ipend_level_hold", 12'h018, 32'h02, 1'b0);
        gpio_din[1] = 1'b0;
        waitCycles(4);
        applyStimulus(12'h018, 32'h02);
        apbRead("ipend_level_drop", 12'h018, 32'h00, 1'b0);

        // Rising edge on pin 2 lands on the same edge as the W1C commit.
        applyStimulus(12'h010, 32'h07);
        @(posedge clk); #1;
        gpio_din[2] = 1'b1;
        @(posedge clk); #1;
        apb_psel = 1'b1; apb_pwrite = 1'b1; apb_paddr = 12'h018; apb_pwdata = 32'h04;
        @(posedge clk); #1;
        apb_penable = 1'b1;
        @(posedge clk); #1;
        apb_psel = 1'b0; apb_penable = 1'b0; apb_pwrite = 1'b0;
        apbRead("ipend_set_wins", 12'h018, 32'h04, 1'b0);
        applyStimulus(12'h018, 32'h04);
        apbRead("ipend_w1c", 12'h018, 32'h00, 1'b0);

        gpio_din[7] = 1'b1;
        waitCycles(4);
        apbRead("ipend7_rise", 12'h018, 32'h00, 1'b0);
        gpio_din[7] = 1'b0;
        waitCycles(4);
        apbRead("ipend7_fall", 12'h018, 32'h80, 1'b0);
        applyStimulus(12'h00C, 32'h80);
        waitCycles(1);
        checkOutput("irq_pin7", 32'(gpio_irq), 32'h1);
        applyStimulus(12'h018, 32'h80);
        waitCycles(1);
        checkOutput("irq_pin7_clr", 32'(gpio_irq), 32'h0);

        apbRead("din_rd", 12'h000, 32'h05, 1'b0);
        apbRead("unmapped_28", 12'h028, 32'h0, 1'b1);
        applyStimulus(12'h028, 32'hFF);
        apbRead("dout_after_bad_wr", 12'h004, 32'hB8, 1'b0);
`ifdef GPIO_DEBOUNCE_EN
        apbRead("dbcnt_rd", 12'h01C, 32'h0, 1'b0);
        applyStimulus(12'h01C, 32'h3);
        gpio_din[3] = 1'b1;
        waitCycles(2);
        gpio_din[3] = 1'b0;
        waitCycles(12);
        apbRead("din_glitch", 12'h000, 32'h05, 1'b0);
        gpio_din[3] = 1'b1;
        waitCycles(20);
        apbRead("din_steady", 12'h000, 32'h0D, 1'b0);
`else
        apbRead("unmapped_1c", 12'h01C, 32'h0, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/gpio_apb_irq.md
# gpio_apb_irq

Parametrised APB general-purpose I/O controller, the next generation of the team's GPIO peripheral. Provides up to 32 pins with per-pin direction, atomic set/clear of outputs, a two-flop input synchroniser and per-pin edge/level interrupts with a write-1-to-clear pending register. Sits on the peripheral APB bus beside the other slow peripherals; its single interrupt line feeds the interrupt controller.

## Interface
- NBITS, 8, number of implemented pins (1..32); unimplemented bits read 0 and ignore writes.
- ADDR_W, 12, APB address bits decoded (byte address; register select uses paddr[5:2]).
- OEPOL, 0, gpio_oen polarity: 0 = low enables output driver, 1 = high enables.
- DOUT_RST, 0, reset value of the output-data register (NBITS wide).
- clk  in  1  system clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- apb_psel  in  1  APB select.
- apb_penable  in  1  APB access phase.
- apb_paddr  in  ADDR_W  APB byte address.
- apb_pwrite  in  1  1 = write.
- apb_pwdata  in  32  write data.
- apb_prdata  out  32  read data.
- apb_pready  out  1  tied 1 (zero wait states).
- apb_pslverr  out  1  1 during access phase to an unmapped offset.
- gpio_din  in  NBITS  asynchronous pad inputs.
- gpio_dout  out  NBITS  output data.
- gpio_oen  out  NBITS  output enables, polarity per OEPOL.
- gpio_irq  out  1  registered interrupt request.

## Operation
- Register map (word offsets): 0x00 DIN RO synchronised input; 0x04 DOUT RW; 0x08 DIR RW (1 = output); 0x0C IMASK RW; 0x10 IPOL RW (1 = rising/high); 0x14 IEDGE RW (1 = edge, 0 = level); 0x18 IPEND R/W1C; 0x1C DBCNT (debounce only); 0x20 DOUT_SET WO; 0x24 DOUT_CLR WO. WO registers read 0.
- Access: write commits when psel & penable & pwrite; read data driven combinationally during access phase, 0 otherwise.
- Input path: gpio_din -> two-flop synchroniser -> sync value s; previous value s_d registered for edge detection.
- Pending set per pin: edge mode: IPOL ? (s & ~s_d) : (~s & s_d); level mode: s == IPOL.
- IPEND write 1 clears; a set event in the same cycle wins (bit stays 1). Level-mode bit re-sets next cycle while level persists.
- gpio_irq = |(IPEND & IMASK), registered.
- DOUT_SET/DOUT_CLR: DOUT |= wdata / DOUT &= ~wdata; single write, no read-modify-write.
- gpio_oen = OEPOL ? DIR : ~DIR.
- Reset values: DOUT = DOUT_RST, DIR/IMASK/IPOL/IEDGE/IPEND = 0, synchroniser flops 0, gpio_irq 0, gpio_oen all inactive, apb_prdata 0, apb_pslverr 0.
- Reset mid-transfer: transfer aborted, no partial register update.

## Timing
- Register write visible on gpio_dout/gpio_oen 1 cycle after the access-phase edge.
- gpio_din change -> DIN readable after 2 edges; IPEND set on edge 3; gpio_irq on edge 4.
- Edge pulses narrower than one clk period may be lost (no requirement).
- Pin 0 and pin NBITS-1 behave identically; no cross-pin dependency.

## Configuration
- GPIO_DEBOUNCE_EN defined: shared 16-bit prescaler reloads from DBCNT (reset 0xFFFF) and emits tick on wrap to 0; per-pin 2-bit stability counter between synchroniser and s; s changes only after 3 consecutive ticks with equal sample. DBCNT = 0 bypasses the filter. Latency grows by up to 3*(DBCNT+1) cycles.
- Not defined: no filter, offset 0x1C unmapped (pslverr), timing as above.

## Structure
- Package gpio_apb_pkg: register offset localparams, max pin count 32, register-select enum.
- One sub-module gpio_debounce (prescaler + per-pin filter), instantiated only under GPIO_DEBOUNCE_EN.

## Test plan
- Reset: after rstn deassert with DOUT_RST = 8'hA5 -> gpio_dout = 8'hA5, gpio_oen = 8'hFF (OEPOL 0), gpio_irq 0, read 0x18 = 0.
- Write DIR = 8'h0F, DOUT = 8'h3C, SET 8'h80, CLR 8'h04 -> gpio_dout = 8'hB8, gpio_oen = 8'hF0, read 0x04 = 0xB8.
- IEDGE = 0x01, IPOL = 0x01, IMASK = 0x01, gpio_din[0] 0->1 -> gpio_irq high 4 cycles later; W1C 0x01 -> irq low next cycle.
- Level mode pin 1 high, IPOL 1: W1C while high -> IPEND[1] re-set next cycle; drop pin then W1C -> stays 0.
- Rising edge coinciding with W1C of same bit -> IPEND bit reads 1.
- Read 0x28 -> pslverr 1, prdata 0; with GPIO_DEBOUNCE_EN, DBCNT = 3, 2-cycle glitch -> DIN unchanged, steady 20-cycle level -> DIN updates.
